// File: rtl/player_health_unit.sv
`default_nettype none
// ============================================================================
//  Module   : player_health_unit
//  Purpose  : Turns the raw player/dragon collision level into frame-qualified
//             hits and tracks lives, invulnerability (with blink), game-over
//             and restart/respawn. Frame pacing comes from rising edges of
//             vsync.
//  Revision : 1.0 - initial release
// ============================================================================
module player_health_unit #(
    parameter int MAX_LIVES      = 3,
    parameter int LIVES_W        = 2,
    parameter int HIT_FRAMES     = 1,
    parameter int INVULN_FRAMES  = 60,
    parameter int RESPAWN_FRAMES = 30,
    parameter int BLINK_BIT      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               collision,
    input  logic               heal,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               player_hurt,
    output logic               invulnerable,
    output logic               blink,
    output logic               game_over,
    output logic [1:0]         state
);

    // ------------------------------------------------------------------------
    // Derived widths and load values
    // ------------------------------------------------------------------------
    localparam int c_fc_max = (INVULN_FRAMES > RESPAWN_FRAMES) ? INVULN_FRAMES
                                                               : RESPAWN_FRAMES;
    localparam int c_fc_w   = $clog2(c_fc_max + 1);
    localparam int c_hc_w   = $clog2(HIT_FRAMES + 1);

    localparam logic [LIVES_W-1:0] c_max_lives    = LIVES_W'(MAX_LIVES);
    localparam logic [c_fc_w-1:0]  c_invuln_load  = c_fc_w'(INVULN_FRAMES);
    localparam logic [c_fc_w-1:0]  c_respawn_load = c_fc_w'(RESPAWN_FRAMES);
    localparam logic [c_fc_w-1:0]  c_fc_one       = c_fc_w'(1);
    localparam logic [c_hc_w-1:0]  c_hit_target   = c_hc_w'(HIT_FRAMES);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'b00,
        ST_INVULN    = 2'b01,
        ST_GAME_OVER = 2'b10,
        ST_RESPAWN   = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    state_t              state_q,        state_d;
    logic [LIVES_W-1:0]  lives_q,        lives_d;
    logic [c_fc_w-1:0]   frame_cnt_q,    frame_cnt_d;
    logic [c_hc_w-1:0]   hit_cnt_q,      hit_cnt_d;
    logic                coll_seen_q,    coll_seen_d;
    logic                vsync_q;
    logic                player_hurt_q,  player_hurt_d;
    logic                invulnerable_q, invulnerable_d;
    logic                blink_q,        blink_d;
    logic                game_over_q,    game_over_d;

    logic                w_tick;
    logic                w_sample;
    logic [c_hc_w-1:0]   w_hit_inc;
    logic                w_blink_src;

    // A frame tick is the first clock with vsync high after it was low.
    assign w_tick    = vsync & ~vsync_q;
    // A collision on the tick cycle itself still belongs to the ending frame.
    assign w_sample  = coll_seen_q | collision;
    // hit_cnt never exceeds HIT_FRAMES-1 between ticks, so this cannot wrap.
    assign w_hit_inc = hit_cnt_q + 1'b1;

    // Blink follows one bit of the countdown; a bit beyond the counter is 0.
    generate
        if (BLINK_BIT < c_fc_w) begin : g_blink_tap
            assign w_blink_src = frame_cnt_d[BLINK_BIT];
        end else begin : g_blink_none
            assign w_blink_src = 1'b0;
        end
    endgenerate

    // Next-state, lives, counters and hurt pulse for the health FSM.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        frame_cnt_d   = frame_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        coll_seen_d   = coll_seen_q;
        player_hurt_d = 1'b0;

        case (state_q)
            ST_ALIVE: begin
                // Latch any collision seen during the frame; a tick consumes it.
                coll_seen_d = w_tick ? 1'b0 : (coll_seen_q | collision);
                if (heal && (lives_q < c_max_lives)) begin
                    lives_d = lives_q + 1'b1;
                end
                if (w_tick) begin
                    if (w_sample) begin
                        if (w_hit_inc == c_hit_target) begin
                            player_hurt_d = 1'b1;
                            hit_cnt_d     = '0;
                            // A same-cycle heal cancels the lost life, so the
                            // result is never 0 and game-over is skipped.
                            lives_d       = heal ? lives_q : (lives_q - 1'b1);
                            if (lives_d == '0) begin
                                state_d = ST_GAME_OVER;
                            end else begin
                                state_d     = ST_INVULN;
                                frame_cnt_d = c_invuln_load;
                            end
                        end else begin
                            hit_cnt_d = w_hit_inc;
                        end
                    end else begin
                        hit_cnt_d = '0;
                    end
                end
            end

            ST_INVULN: begin
                coll_seen_d = 1'b0;
                hit_cnt_d   = '0;
                if (heal && (lives_q < c_max_lives)) begin
                    lives_d = lives_q + 1'b1;
                end
                if (w_tick) begin
                    if (frame_cnt_q <= c_fc_one) begin
                        state_d     = ST_ALIVE;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 1'b1;
                    end
                end
            end

            ST_GAME_OVER: begin
                coll_seen_d = 1'b0;
                hit_cnt_d   = '0;
                lives_d     = '0;
            end

            ST_RESPAWN: begin
                coll_seen_d = 1'b0;
                hit_cnt_d   = '0;
                lives_d     = c_max_lives;
                if (w_tick) begin
                    if (frame_cnt_q <= c_fc_one) begin
                        state_d     = ST_ALIVE;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_ALIVE;
            end
        endcase

        // Restart wins over everything, including a hit on the same cycle.
        if (restart) begin
            state_d       = ST_RESPAWN;
            lives_d       = c_max_lives;
            frame_cnt_d   = c_respawn_load;
            hit_cnt_d     = '0;
            coll_seen_d   = 1'b0;
            player_hurt_d = 1'b0;
        end
    end

    // Status outputs decoded from the next state so they register alongside it.
    always_comb begin
        invulnerable_d = (state_d == ST_INVULN) || (state_d == ST_RESPAWN);
        game_over_d    = (state_d == ST_GAME_OVER);
        blink_d        = (state_d == ST_INVULN) && w_blink_src;
    end

    // Register bank with asynchronous reset to the fresh-game condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ALIVE;
            lives_q        <= c_max_lives;
            frame_cnt_q    <= '0;
            hit_cnt_q      <= '0;
            coll_seen_q    <= 1'b0;
            vsync_q        <= 1'b0;
            player_hurt_q  <= 1'b0;
            invulnerable_q <= 1'b0;
            blink_q        <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            frame_cnt_q    <= frame_cnt_d;
            hit_cnt_q      <= hit_cnt_d;
            coll_seen_q    <= coll_seen_d;
            vsync_q        <= vsync;
            player_hurt_q  <= player_hurt_d;
            invulnerable_q <= invulnerable_d;
            blink_q        <= blink_d;
            game_over_q    <= game_over_d;
        end
    end

    assign lives        = lives_q;
    assign player_hurt  = player_hurt_q;
    assign invulnerable = invulnerable_q;
    assign blink        = blink_q;
    assign game_over    = game_over_q;
    assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_player_health_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_player_health_unit
//  Purpose  : Scoreboard bench for player_health_unit. Two instances: A with
//             HIT_FRAMES=1, B with HIT_FRAMES=2; both INVULN_FRAMES=4,
//             RESPAWN_FRAMES=3, BLINK_BIT=1, MAX_LIVES=3. Expected output
//             vectors {hurt,state,lives,inv,blink,game_over} are queued with
//             the frame number at which they must appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_player_health_unit;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic vsync     = 1'b0;
    logic coll_a    = 1'b0;
    logic coll_b    = 1'b0;
    logic heal_a    = 1'b0;
    logic restart_a = 1'b0;
    logic heal_b    = 1'b0;
    logic restart_b = 1'b0;
    logic done      = 1'b0;

    logic [1:0] lives_a, state_a, lives_b, state_b;
    logic       hurt_a, inv_a, blink_a, go_a;
    logic       hurt_b, inv_b, blink_b, go_b;

    always #5 clk = ~clk;

    player_health_unit #(
        .MAX_LIVES(3), .LIVES_W(2), .HIT_FRAMES(1),
        .INVULN_FRAMES(4), .RESPAWN_FRAMES(3), .BLINK_BIT(1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .vsync(vsync), .collision(coll_a),
        .heal(heal_a), .restart(restart_a), .lives(lives_a),
        .player_hurt(hurt_a), .invulnerable(inv_a), .blink(blink_a),
        .game_over(go_a), .state(state_a)
    );

    player_health_unit #(
        .MAX_LIVES(3), .LIVES_W(2), .HIT_FRAMES(2),
        .INVULN_FRAMES(4), .RESPAWN_FRAMES(3), .BLINK_BIT(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .vsync(vsync), .collision(coll_b),
        .heal(heal_b), .restart(restart_b), .lives(lives_b),
        .player_hurt(hurt_b), .invulnerable(inv_b), .blink(blink_b),
        .game_over(go_b), .state(state_b)
    );

    // w=1: the change must be visible right after an asynchronous reset edge.
    typedef struct packed {
        logic        w;
        logic [31:0] t;
        logic [7:0]  v;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   tick_no = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    function automatic logic [7:0] vec(input int h, input int s, input int l,
                                       input int i, input int b, input int g);
        return {h[0], s[1:0], l[1:0], i[0], b[0], g[0]};
    endfunction

    task automatic ea(input int dt, input logic [7:0] v);
        qa.push_back('{w: 1'b0, t: 32'(tick_no + dt), v: v});
    endtask

    task automatic eb(input int dt, input logic [7:0] v);
        qb.push_back('{w: 1'b0, t: 32'(tick_no + dt), v: v});
    endtask

    task automatic ew(input int inst, input int dt, input logic [7:0] v);
        if (inst == 0) qa.push_back('{w: 1'b1, t: 32'(tick_no + dt), v: v});
        else           qb.push_back('{w: 1'b1, t: 32'(tick_no + dt), v: v});
    endtask

    // One frame: 3 cycles of vsync low then the tick cycle. Collision levels
    // hold for the whole frame including the tick; heal only on the tick.
    task automatic frame(input logic ca, input logic cb, input logic ha);
        coll_a = ca;
        coll_b = cb;
        vsync  = 1'b0;
        repeat (3) @(negedge clk);
        vsync  = 1'b1;
        heal_a = ha;
        tick_no++;
        @(negedge clk);
        vsync  = 1'b0;
        coll_a = 1'b0;
        coll_b = 1'b0;
        heal_a = 1'b0;
    endtask

    task automatic pulse_heal();
        heal_a = 1'b1;
        @(negedge clk);
        heal_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_restart();
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] cur, input logic [7:0] prev,
                       input logic empty, input exp_t e, input logic rw);
        if (prev[7] === 1'b1) begin
            n_cmp++;
            if (cur[7] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hurt_width: hurt=%b on cycle after pulse, want 0", nm, cur[7]);
            end
        end
        if (cur !== prev) begin
            n_cmp++;
            if (empty) begin
                n_fail++;
                $display("FAIL %s unexpected_change: got %b at tick %0d, want no change",
                         nm, cur, tick_no);
            end else if (cur !== e.v || e.t != 32'(tick_no) || e.w != rw) begin
                n_fail++;
                $display("FAIL %s vector: got %b tick %0d async %b, want %b tick %0d async %b",
                         nm, cur, tick_no, rw, e.v, e.t, e.w);
            end
        end
    endtask

    // Monitor: pops an expectation whenever an instance's output vector changes.
    initial begin
        logic [7:0] cur_a, prev_a, cur_b, prev_b;
        logic       last_rst, rwake, emp;
        exp_t       e;
        prev_a   = 8'hxx;
        prev_b   = 8'hxx;
        last_rst = 1'b1;
        while (!done) begin
            @(negedge clk or posedge reset);
            rwake = reset && !last_rst;
            #1;
            last_rst = reset;
            cur_a = {hurt_a, state_a, lives_a, inv_a, blink_a, go_a};
            cur_b = {hurt_b, state_b, lives_b, inv_b, blink_b, go_b};

            emp = (qa.size() == 0);
            e   = '0;
            if (cur_a !== prev_a && !emp) e = qa.pop_front();
            chk("A", cur_a, prev_a, emp, e, rwake);
            prev_a = cur_a;

            emp = (qb.size() == 0);
            e   = '0;
            if (cur_b !== prev_b && !emp) e = qb.pop_front();
            chk("B", cur_b, prev_b, emp, e, rwake);
            prev_b = cur_b;
        end
        while (qa.size() > 0) begin
            e = qa.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL A missing: never saw %b at tick %0d", e.v, e.t);
        end
        while (qb.size() > 0) begin
            e = qb.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL B missing: never saw %b at tick %0d", e.v, e.t);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        ea(0, vec(0, 0, 3, 0, 0, 0));
        eb(0, vec(0, 0, 3, 0, 0, 0));
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // B (HIT_FRAMES=2): collision pattern 1,0,1,1 -> single hit at 4th tick.
        eb(4, vec(1, 1, 2, 1, 0, 0));
        eb(4, vec(0, 1, 2, 1, 0, 0));
        eb(5, vec(0, 1, 2, 1, 1, 0));
        eb(7, vec(0, 1, 2, 1, 0, 0));
        eb(8, vec(0, 0, 2, 0, 0, 0));
        frame(0, 1, 0); frame(0, 0, 0); frame(0, 1, 0); frame(0, 1, 0);
        repeat (4) frame(0, 0, 0);

        // A: collision held 3 frames, hit at first, ALIVE after 4 ticks, re-hit.
        ea(1, vec(1, 1, 2, 1, 0, 0));
        ea(1, vec(0, 1, 2, 1, 0, 0));
        ea(2, vec(0, 1, 2, 1, 1, 0));
        ea(4, vec(0, 1, 2, 1, 0, 0));
        ea(5, vec(0, 0, 2, 0, 0, 0));
        ea(6, vec(1, 1, 1, 1, 0, 0));
        ea(6, vec(0, 1, 1, 1, 0, 0));
        frame(1, 0, 0); frame(1, 0, 0); frame(1, 0, 0);
        frame(0, 0, 0); frame(0, 0, 0); frame(1, 0, 0);
        ea(1, vec(0, 1, 1, 1, 1, 0));
        ea(3, vec(0, 1, 1, 1, 0, 0));
        ea(4, vec(0, 0, 1, 0, 0, 0));
        repeat (4) frame(0, 0, 0);

        // lives=1: heal and completing hit together, then heal inside INVULN.
        ea(1, vec(1, 1, 1, 1, 0, 0));
        ea(1, vec(0, 1, 2, 1, 0, 0));
        ea(2, vec(0, 1, 2, 1, 1, 0));
        ea(4, vec(0, 1, 2, 1, 0, 0));
        ea(5, vec(0, 0, 2, 0, 0, 0));
        frame(1, 0, 1);
        pulse_heal();
        repeat (4) frame(0, 0, 0);

        // Heal to MAX, then heal at MAX saturates.
        ea(0, vec(0, 0, 3, 0, 0, 0));
        pulse_heal();
        pulse_heal();

        // Three separated hits -> game over.
        ea(1, vec(1, 1, 2, 1, 0, 0));
        ea(1, vec(0, 1, 2, 1, 0, 0));
        ea(2, vec(0, 1, 2, 1, 1, 0));
        ea(4, vec(0, 1, 2, 1, 0, 0));
        ea(5, vec(0, 0, 2, 0, 0, 0));
        frame(1, 0, 0);
        repeat (4) frame(0, 0, 0);
        ea(1, vec(1, 1, 1, 1, 0, 0));
        ea(1, vec(0, 1, 1, 1, 0, 0));
        ea(2, vec(0, 1, 1, 1, 1, 0));
        ea(4, vec(0, 1, 1, 1, 0, 0));
        ea(5, vec(0, 0, 1, 0, 0, 0));
        frame(1, 0, 0);
        repeat (4) frame(0, 0, 0);
        ea(1, vec(1, 2, 0, 0, 0, 1));
        ea(1, vec(0, 2, 0, 0, 0, 1));
        frame(1, 0, 0);
        pulse_heal();
        frame(1, 0, 0);

        // Restart: RESPAWN with MAX lives, collisions ignored, ALIVE after 3 ticks.
        ea(0, vec(0, 3, 3, 1, 0, 0));
        pulse_restart();
        ea(3, vec(0, 0, 3, 0, 0, 0));
        repeat (3) frame(1, 0, 0);

        // Asynchronous reset mid-INVULN with frame_cnt=2.
        ea(1, vec(1, 1, 2, 1, 0, 0));
        ea(1, vec(0, 1, 2, 1, 0, 0));
        ea(2, vec(0, 1, 2, 1, 1, 0));
        ew(0, 3, vec(0, 0, 3, 0, 0, 0));
        ew(1, 3, vec(0, 0, 3, 0, 0, 0));
        frame(1, 0, 0); frame(0, 0, 0); frame(0, 0, 0);
        #2;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // After release: a quiet tick gives no hit, a colliding one does.
        ea(2, vec(1, 1, 2, 1, 0, 0));
        ea(2, vec(0, 1, 2, 1, 0, 0));
        frame(0, 0, 0);
        frame(1, 0, 0);
        repeat (3) @(negedge clk);
        done = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/player_health_unit.md
# player_health_unit

Parametrised successor to the heart/lives tracker in the top-level game. It converts the raw player–dragon collision flag into frame-qualified damage events. It also manages lives, post-hit invulnerability with a blink flag for the PPU, game-over, and restart/respawn. It sits between `CollisionDetector` and `PlayerLogic`/`PictureProcessingUnit`/`AudioProcessingUnit`, clocked by the pixel clock and paced by `vsync`.

## Interface
Parameters:
- `MAX_LIVES`, 3, lives loaded at reset/restart; must satisfy 1 ≤ MAX_LIVES < 2^LIVES_W
- `LIVES_W`, 2, width of `lives`
- `HIT_FRAMES`, 1, consecutive frames with collision required to register one hit (≥1)
- `INVULN_FRAMES`, 60, frames of invulnerability after a non-fatal hit (≥1)
- `RESPAWN_FRAMES`, 30, frames of invulnerability after restart (≥1)
- `BLINK_BIT`, 2, frame-counter bit driving `blink`

Ports:
- `clk` in 1 — system clock
- `reset` in 1 — asynchronous, active-high
- `vsync` in 1 — from `sync_generator`; its rising edge is the frame tick
- `collision` in 1 — player–dragon collision, any-cycle level
- `heal` in 1 — single-cycle pulse, +1 life
- `restart` in 1 — single-cycle pulse, reload lives and respawn
- `lives` out LIVES_W — current lives
- `player_hurt` out 1 — one-cycle pulse per registered hit
- `invulnerable` out 1 — high in INVULN and RESPAWN
- `blink` out 1 — sprite-hide flag during INVULN
- `game_over` out 1 — high in GAME_OVER
- `state` out 2 — 00 ALIVE, 01 INVULN, 10 GAME_OVER, 11 RESPAWN

## Operation
- Frame tick: `vsync_q` is `vsync` registered. `tick = vsync & ~vsync_q`. All frame-rate decisions are made on `tick` cycles.
- Collision latch `coll_seen`:
  - set on any cycle with `collision=1` in ALIVE;
  - the effective sample at a tick is `coll_seen | collision`;
  - cleared on every tick;
  - held at 0 outside ALIVE.
- ALIVE, at tick:
  - If the sample is 1, `hit_cnt` increments (saturating at HIT_FRAMES); otherwise `hit_cnt` goes to 0.
  - When the increment reaches HIT_FRAMES, a hit is taken: `player_hurt` pulses, `hit_cnt` goes to 0, and `lives` decrements.
  - If the resulting lives = 0, go to GAME_OVER; otherwise go to INVULN with `frame_cnt = INVULN_FRAMES`.
- INVULN:
  - `collision` is ignored and `hit_cnt` is held at 0.
  - Each tick decrements `frame_cnt`. A tick with `frame_cnt = 1` goes to ALIVE.
  - `blink = frame_cnt[BLINK_BIT]`.
- GAME_OVER: `lives = 0`, `heal` is ignored, `blink = 0`. Only `restart` exits.
- RESPAWN:
  - `lives = MAX_LIVES`, collision is ignored, `blink = 0`.
  - Counts down from RESPAWN_FRAMES per tick, the same way as INVULN; exits to ALIVE.
- `heal` in ALIVE or INVULN: `lives + 1`, saturating at MAX_LIVES. Does not change state or counters.
- Simultaneous hit and heal in the same cycle: `lives_next = sat(lives − 1 + 1)`, so lives are unchanged. `player_hurt` still pulses and the state goes to INVULN. GAME_OVER is never entered from this case.
- `restart` in any state (highest priority, including over a same-cycle hit): `lives = MAX_LIVES`, go to RESPAWN with `frame_cnt = RESPAWN_FRAMES`, `hit_cnt = 0`, `coll_seen = 0`, no `player_hurt`.
- Widths:
  - `frame_cnt` is `$clog2(max(INVULN_FRAMES, RESPAWN_FRAMES)+1)` bits;
  - `hit_cnt` is `$clog2(HIT_FRAMES+1)` bits;
  - lives arithmetic is unsigned and never wraps.

## Timing
- All outputs are registered and update on the `clk` edge at which the qualifying input/tick is sampled. They are visible the following cycle.
- Reset (asynchronous, any time, including mid-INVULN):
  - `lives = MAX_LIVES`, `state = ALIVE`;
  - `player_hurt = invulnerable = blink = game_over = 0`;
  - `vsync_q = 0`, `coll_seen = 0`, `hit_cnt = 0`, `frame_cnt = 0`.
- The first tick after reset occurs only if `vsync` is 1 after `vsync_q` is 0. If `vsync` is high out of reset, a spurious first tick is allowed.
- Hit latency: one cycle after the tick that completes HIT_FRAMES. `player_hurt` is exactly one cycle wide; at most one pulse per frame.
- Invulnerability lasts exactly INVULN_FRAMES ticks. The first tick after the hit tick counts as 1.
- A collision on the tick cycle counts toward that frame. A collision in the cycle immediately after the tick counts toward the next frame.

## Test plan
- Reset, then collision held 3 frames with HIT_FRAMES=1, INVULN_FRAMES=4:
  - `player_hurt` pulses once at tick 1, `lives` 3→2, state=01;
  - state=00 after 4 more ticks;
  - a second hit occurs on the next colliding tick.
- HIT_FRAMES=2, collision pattern 1,0,1,1 per frame → single hit at the 4th tick only, `lives` 3→2.
- Three separated hits → `lives` 0, `game_over=1`, state=10. Then `heal` → no change. Then `restart` → `lives=3`, state=11, ALIVE after RESPAWN_FRAMES ticks, no `player_hurt`.
- `lives=1`, `heal` and completing hit on the same cycle → `lives=1`, `player_hurt=1`, state=01, `game_over=0`.
- `heal` at `lives=MAX_LIVES` → stays 3. During INVULN, `blink` toggles every 2^BLINK_BIT ticks and collisions produce no hurt.
- Assert `reset` mid-INVULN with `frame_cnt=2` → outputs return to reset values immediately (asynchronous). After release, the first tick does not hit unless collision is present.
